// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared counter type and round-robin pointer helper for sram_rd_arbiter.
package sram_arb_pkg;
   localparam int STAT_CNT_W = 32;
   typedef logic [STAT_CNT_W-1:0] stat_cnt_t;
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr == n - 1) ? 0 : ptr + 1;
   endfunction
endpackage

// File: rtl/sram_rd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting at rr_ptr, wrapping NUM_REQ-1 -> 0.
module rr_pick #(
   parameter int NUM_REQ = 4,
   localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] rr_ptr,
   output logic [ID_WIDTH-1:0] grant,
   output logic                any_valid
);
   logic [ID_WIDTH:0] idx;
   // Walk offsets from farthest to nearest so the nearest valid requester wins.
   always_comb begin
      grant = '0;
      idx = '0;
      any_valid = |req;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
         idx = (idx >= (ID_WIDTH+1)'(NUM_REQ)) ? idx - (ID_WIDTH+1)'(NUM_REQ) : idx;
         if (req[idx[ID_WIDTH-1:0]])
            grant = idx[ID_WIDTH-1:0];
      end
   end
endmodule

// File: rtl/sram_rd_arbiter.sv
// sram_rd_arbiter: round-robin share of one SRAM read port among NUM_REQ valid/ready requesters.
// Define SRAM_RD_ARB_STATS_EN to add per-requester grant counters and a stall counter.
module sram_rd_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH = 2,
   localparam int ADDR_WIDTH = $clog2(DEPTH),
   localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          arst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   input  logic [NUM_REQ-1:0]            resp_ready,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic                          sram_rd,
   output logic [ADDR_WIDTH-1:0]         sram_rd_addr,
   input  logic [DATA_WIDTH-1:0]         sram_rd_dout
`ifdef SRAM_RD_ARB_STATS_EN
   ,
   output logic [NUM_REQ*STAT_CNT_W-1:0] stat_grant_cnt,
   output stat_cnt_t                     stat_stall_cnt
`endif
);
   logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, g;
   logic                pend_q, pend_d, any_valid, slot_free, issue;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req       (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (g),
      .any_valid (any_valid)
   );

   // Reset also masks issue so req_ready and sram_rd stay low while arst_n is held.
   always_comb begin
      slot_free = !pend_q || resp_ready[owner_q];
      issue = arst_n && slot_free && any_valid;
      req_ready = issue ? NUM_REQ'(1) << g : '0;
      sram_rd = issue;
      sram_rd_addr = issue ? req_addr[g*ADDR_WIDTH +: ADDR_WIDTH] : '0;
      resp_valid = pend_q ? NUM_REQ'(1) << owner_q : '0;
      resp_data = sram_rd_dout;
      pend_d = issue || (pend_q && !resp_ready[owner_q]);
      owner_d = issue ? g : owner_q;
      rr_ptr_d = issue ? ID_WIDTH'(rr_next(32'(g), 32'(NUM_REQ))) : rr_ptr_q;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rr_ptr_q <= '0;
         owner_q <= '0;
         pend_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         owner_q <= owner_d;
         pend_q <= pend_d;
      end
   end

`ifdef SRAM_RD_ARB_STATS_EN
   logic [NUM_REQ*STAT_CNT_W-1:0] grant_cnt_q, grant_cnt_d;
   stat_cnt_t                     stall_cnt_q, stall_cnt_d;

   always_comb begin
      grant_cnt_d = grant_cnt_q;
      if (issue)
         grant_cnt_d[g*STAT_CNT_W +: STAT_CNT_W] = grant_cnt_q[g*STAT_CNT_W +: STAT_CNT_W] + stat_cnt_t'(1);
      stall_cnt_d = stall_cnt_q + stat_cnt_t'(any_valid && !slot_free);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stat_grant_cnt = grant_cnt_q;
   assign stat_stall_cnt = stall_cnt_q;

   final begin
      for (int i = 0; i < NUM_REQ; i++)
         $display("[%m] grant[%0d]: %0d", i, grant_cnt_q[i*STAT_CNT_W +: STAT_CNT_W]);
      $display("[%m] stall: %0d", stall_cnt_q);
   end
`endif
endmodule

// File: tb/tb_sram_rd_arbiter.sv
// tb_sram_rd_arbiter: directed and randomized checks of sram_rd_arbiter against a
// transaction-queue model of the arbiter and a behavioural 1-cycle-latency SRAM.
module tb_sram_rd_arbiter;
   localparam int N = 4;

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic [3:0] req_valid = '0, req_addr = '0, resp_ready = '1;
   logic [3:0] req_ready, resp_valid;
   logic [7:0] resp_data, sram_rd_dout;
   logic       sram_rd, sram_rd_addr;
   logic [2:0] v3 = '0, a3 = '0, rr3 = '1;
   logic [2:0] rdy3, rv3;
   logic [7:0] d3, dout3;
   logic       rd3, ra3;
   logic [7:0] mem [2];
   int         n_assert = 0, n_fail = 0;
   bit         mon_en = 1'b0;
`ifdef SRAM_RD_ARB_STATS_EN
   logic [4*32-1:0] stat_grant_cnt;
   logic [31:0]     stat_stall_cnt;
   logic [3*32-1:0] sg3;
   logic [31:0]     ss3;
`endif

   always #5 clk = ~clk;

   sram_rd_arbiter u_dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .sram_rd      (sram_rd),
      .sram_rd_addr (sram_rd_addr),
      .sram_rd_dout (sram_rd_dout)
`ifdef SRAM_RD_ARB_STATS_EN
      ,
      .stat_grant_cnt (stat_grant_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   sram_rd_arbiter #(.NUM_REQ(3)) u_dut3 (
      .clk          (clk),
      .arst_n       (arst_n),
      .req_valid    (v3),
      .req_addr     (a3),
      .req_ready    (rdy3),
      .resp_valid   (rv3),
      .resp_ready   (rr3),
      .resp_data    (d3),
      .sram_rd      (rd3),
      .sram_rd_addr (ra3),
      .sram_rd_dout (dout3)
`ifdef SRAM_RD_ARB_STATS_EN
      ,
      .stat_grant_cnt (sg3),
      .stat_stall_cnt (ss3)
`endif
   );

   // Behavioural SRAMs: read data appears one edge after rd and holds while rd is low.
   always @(posedge clk or negedge arst_n)
      if (!arst_n) sram_rd_dout <= '0;
      else if (sram_rd) sram_rd_dout <= mem[sram_rd_addr];

   always @(posedge clk or negedge arst_n)
      if (!arst_n) dout3 <= '0;
      else if (rd3) dout3 <= mem[ra3];

   // Reference model: a queue of outstanding reads plus the next search start.
   typedef struct { int id; int addr; } txn_t;
   txn_t q[$];
   int   start = 0;

   function automatic int pick(input logic [3:0] v, input int s);
      for (int k = 0; k < N; k++)
         if (v[(s + k) % N]) return (s + k) % N;
      return -1;
   endfunction

   always @(posedge clk or negedge arst_n) begin : model
      int g;
      bit fr;
      if (!arst_n) begin
         q.delete();
         start = 0;
      end else begin
         fr = (q.size() == 0) || resp_ready[q[0].id];
         g = pick(req_valid, start);
         if (q.size() != 0 && resp_ready[q[0].id]) void'(q.pop_front());
         if (fr && g >= 0) begin
            q.push_back('{g, int'(req_addr[g])});
            start = (g + 1) % N;
         end
      end
   end

   always @(negedge clk) if (mon_en) begin : mon
      int g;
      bit fr, iss;
      logic [3:0] er, ev;
      logic ea;
      fr = (q.size() == 0) || resp_ready[q[0].id];
      g = pick(req_valid, start);
      iss = arst_n && fr && g >= 0;
      er = iss ? 4'b0001 << g : 4'b0000;
      ea = iss ? req_addr[g] : 1'b0;
      ev = (q.size() != 0) ? 4'b0001 << q[0].id : 4'b0000;
      n_assert += 4;
      if (req_ready !== er) begin n_fail++; $display("FAIL mon_req_ready t=%0t got %b exp %b", $time, req_ready, er); end
      if (sram_rd !== iss) begin n_fail++; $display("FAIL mon_sram_rd t=%0t got %b exp %b", $time, sram_rd, iss); end
      if (sram_rd_addr !== ea) begin n_fail++; $display("FAIL mon_sram_rd_addr t=%0t got %b exp %b", $time, sram_rd_addr, ea); end
      if (resp_valid !== ev) begin n_fail++; $display("FAIL mon_resp_valid t=%0t got %b exp %b", $time, resp_valid, ev); end
      if (q.size() != 0) begin
         n_assert++;
         if (resp_data !== mem[q[0].addr]) begin n_fail++; $display("FAIL mon_resp_data t=%0t got %h exp %h", $time, resp_data, mem[q[0].addr]); end
      end
   end

   // Requester protocol: an unaccepted request stays valid with a stable address.
   logic [3:0] hold = '0, haddr = '0;
   always @(negedge clk) begin
      if (!arst_n) hold = '0;
      else begin
         for (int i = 0; i < N; i++)
            if (hold[i]) begin
               n_assert++;
               if (!req_valid[i] || req_addr[i] !== haddr[i]) begin
                  n_fail++;
                  $display("FAIL req_hold i=%0d t=%0t got v=%b a=%b exp v=1 a=%b", i, $time, req_valid[i], req_addr[i], haddr[i]);
               end
            end
         hold = req_valid & ~req_ready;
         haddr = req_addr;
      end
   end

   task automatic do_reset();
      arst_n = 1'b0;
      req_valid = '0;
      req_addr = '0;
      resp_ready = '1;
      v3 = '0;
      rr3 = '1;
      @(posedge clk); #1;
      arst_n = 1'b1;
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      req_valid = 4'hF;
      repeat (2) @(posedge clk);
      #1 mon_en = 1'b1;
      @(negedge clk);
      n_assert += 3;
      if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
      if (resp_valid !== 4'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0000", resp_valid); end
      if (sram_rd !== 1'b0) begin n_fail++; $display("FAIL reset_sram_rd got %b exp 0", sram_rd); end
      @(posedge clk); #1;
      arst_n = 1'b1;
      @(negedge clk);
      n_assert++;
      if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got %b exp 0001", req_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      int exp_g [5] = '{0, 1, 2, 3, 0};
      logic [7:0] exp_d [5] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
      do_reset();
      req_valid = 4'hF;
      req_addr = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k < 5) begin
            n_assert++;
            if (req_ready !== 4'b0001 << exp_g[k]) begin n_fail++; $display("FAIL rr_grant k=%0d got %b exp %b", k, req_ready, 4'b0001 << exp_g[k]); end
         end
         if (k > 0) begin
            n_assert += 2;
            if (resp_valid !== 4'b0001 << exp_g[k-1]) begin n_fail++; $display("FAIL rr_resp_valid k=%0d got %b exp %b", k, resp_valid, 4'b0001 << exp_g[k-1]); end
            if (resp_data !== exp_d[k-1]) begin n_fail++; $display("FAIL rr_resp_data k=%0d got %h exp %h", k, resp_data, exp_d[k-1]); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      do_reset();
      req_valid = 4'b0100;
      req_addr = 4'b0100;
      resp_ready = 4'b1011;
      @(negedge clk);
      n_assert++;
      if (req_ready !== 4'b0100 || sram_rd !== 1'b1) begin n_fail++; $display("FAIL stall_issue got rdy=%b rd=%b exp rdy=0100 rd=1", req_ready, sram_rd); end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_assert += 3;
         if (resp_valid !== 4'b0100) begin n_fail++; $display("FAIL stall_resp_valid k=%0d got %b exp 0100", k, resp_valid); end
         if (resp_data !== 8'h3C) begin n_fail++; $display("FAIL stall_resp_data k=%0d got %h exp 3c", k, resp_data); end
         if (sram_rd !== 1'b0 || req_ready !== 4'b0) begin n_fail++; $display("FAIL stall_no_issue k=%0d got rd=%b rdy=%b exp rd=0 rdy=0000", k, sram_rd, req_ready); end
         @(posedge clk); #1;
      end
      resp_ready = '1;
      @(negedge clk);
      n_assert++;
      if (resp_valid !== 4'b0100 || req_ready !== 4'b0100 || sram_rd !== 1'b1) begin
         n_fail++; $display("FAIL stall_accept_issue got rv=%b rdy=%b rd=%b exp rv=0100 rdy=0100 rd=1", resp_valid, req_ready, sram_rd);
      end
      @(posedge clk); #1;
      req_valid = '0;
   endtask

   task automatic test_wrap();
      logic [3:0] vs [4] = '{4'b0010, 4'b1010, 4'b1010, 4'b1000};
      logic [3:0] es [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
      logic [2:0] v3s [4] = '{3'b010, 3'b101, 3'b101, 3'b100};
      logic [2:0] e3s [4] = '{3'b010, 3'b100, 3'b001, 3'b100};
      do_reset();
      a3 = 3'b010;
      for (int k = 0; k < 4; k++) begin
         req_valid = vs[k];
         v3 = v3s[k];
         @(negedge clk);
         n_assert += 2;
         if (req_ready !== es[k]) begin n_fail++; $display("FAIL wrap4 k=%0d got %b exp %b", k, req_ready, es[k]); end
         if (rdy3 !== e3s[k]) begin n_fail++; $display("FAIL wrap3 k=%0d got %b exp %b", k, rdy3, e3s[k]); end
         if (k == 1) begin
            n_assert += 2;
            if (rv3 !== 3'b010) begin n_fail++; $display("FAIL wrap3_resp_valid got %b exp 010", rv3); end
            if (d3 !== 8'h3C) begin n_fail++; $display("FAIL wrap3_resp_data got %h exp 3c", d3); end
         end
         @(posedge clk); #1;
      end
      req_valid = '0;
      v3 = '0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      req_valid = 4'b0100;
      @(negedge clk);
      n_assert++;
      if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL mrst_issue got %b exp 0100", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'hF;
      n_assert++;
      if (resp_valid !== 4'b0100) begin n_fail++; $display("FAIL mrst_pending got %b exp 0100", resp_valid); end
      arst_n = 1'b0;
      #1;
      n_assert += 2;
      if (resp_valid !== 4'b0) begin n_fail++; $display("FAIL mrst_drop got %b exp 0000", resp_valid); end
      if (req_ready !== 4'b0) begin n_fail++; $display("FAIL mrst_ready got %b exp 0000", req_ready); end
      @(posedge clk); #1;
      arst_n = 1'b1;
      @(negedge clk);
      n_assert += 2;
      if (resp_valid !== 4'b0) begin n_fail++; $display("FAIL mrst_no_delivery got %b exp 0000", resp_valid); end
      if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mrst_ptr_cleared got %b exp 0001", req_ready); end
      @(posedge clk); #1;
   endtask

`ifdef SRAM_RD_ARB_STATS_EN
   task automatic test_stats();
      int eg [4] = '{2, 1, 1, 1};
      do_reset();
      req_valid = 4'hF;
      req_addr = 4'b1010;
      repeat (5) begin @(posedge clk); #1; end
      resp_ready = 4'b1110;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         n_assert++;
         if (stat_grant_cnt[i*32 +: 32] !== 32'(eg[i])) begin n_fail++; $display("FAIL stat_grant i=%0d got %0d exp %0d", i, stat_grant_cnt[i*32 +: 32], eg[i]); end
      end
      n_assert += 2;
      if (stat_stall_cnt !== 32'd3) begin n_fail++; $display("FAIL stat_stall got %0d exp 3", stat_stall_cnt); end
      if (ss3 !== 32'd0 || sg3 !== '0) begin n_fail++; $display("FAIL stat3_idle got stall=%0d grants=%h exp 0", ss3, sg3); end
      @(posedge clk); #1;
   endtask
`endif

   task automatic test_random();
      logic [3:0] acc = '0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i] || acc[i]) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               req_addr[i] = 1'($urandom_range(0, 1));
            end
         resp_ready = 4'($urandom) | 4'($urandom);
         @(negedge clk);
         acc = req_ready;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      mem[0] = 8'hA5;
      mem[1] = 8'h3C;
      test_reset();
      test_round_robin();
      test_stall();
      test_wrap();
      test_mid_reset();
`ifdef SRAM_RD_ARB_STATS_EN
      test_stats();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
